// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared state encodings, parity/prescale constants and helpers for the UART receiver
// No ports: imported by uart_rx_bit_sampler and uart_receiver.
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic prescale_is_legal(input int p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// rtl/uart_rx_bit_sampler.sv - line synchroniser, per-bit oversample counter and 3-sample majority vote
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   serial_in         raw RX line (asynchronous to clk)
//   prescale          frame-latched oversample ticks per bit
//   active            1 while the receiver is inside a frame; 0 holds the counter at zero
//   rx_s              synchronised line
//   sampled_bit       majority of the three mid-bit samples (meaningful with sample_strobe)
//   sample_strobe     decision cycle (edge_cnt = P/2+1)
//   bit_end           last tick of the bit (edge_cnt = P-1)
module uart_rx_bit_sampler
    import uart_receiver_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      serial_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      active,
    output logic                      rx_s,
    output logic                      sampled_bit,
    output logic                      sample_strobe,
    output logic                      bit_end
);

    logic                      sync1_q;
    logic                      sync2_q;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_d;
    logic                      samp0_q;
    logic                      samp1_q;
    logic [PRESCALE_WIDTH-1:0] half;

    assign half = prescale >> 1;
    assign rx_s = sync2_q;

    assign bit_end       = active && (edge_cnt_q == prescale - PRESCALE_WIDTH'(1));
    assign sample_strobe = active && (edge_cnt_q == half + PRESCALE_WIDTH'(1));
    // Third sample is the live synchronised line in the decision cycle itself.
    assign sampled_bit   = majority3(samp0_q, samp1_q, rx_s);

    always_comb begin
        edge_cnt_d = '0;
        if (active && !bit_end) begin
            edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            edge_cnt_q <= '0;
            samp0_q    <= 1'b1;
            samp1_q    <= 1'b1;
        end else begin
            sync1_q    <= serial_in;
            sync2_q    <= sync1_q;
            edge_cnt_q <= edge_cnt_d;
            if (edge_cnt_q == half - PRESCALE_WIDTH'(1)) begin
                samp0_q <= rx_s;
            end
            if (edge_cnt_q == half) begin
                samp1_q <= rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART RX frame FSM, shift register, parity check and level-held result registers
// Ports:
//   clk, reset_n      UART oversampling clock, asynchronous active-low reset
//   serial_in         RX line, idle high
//   prescale          oversample ticks per bit (8, 16 or 32), latched at start detection
//   parity_enable     1 = parity bit present
//   parity_type       0 = even, 1 = odd
//   parallel_data     data of the last good frame; only changes on a good frame
//   data_valid        high while parallel_data holds a good frame, cleared by the next start
//   parity_error      last frame had a parity mismatch
//   framing_error     last frame had a low stop bit
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      serial_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    output logic [DATA_WIDTH-1:0]     parallel_data,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      framing_error
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state_q;
    logic [PRESCALE_WIDTH-1:0] p_q;
    logic [BCW-1:0]            bit_cnt_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic                      par_err_q;
    logic [DATA_WIDTH-1:0]     parallel_data_q;
    logic                      data_valid_q;
    logic                      parity_error_q;
    logic                      framing_error_q;

    logic rx_s;
    logic sampled_bit;
    logic sample_strobe;
    logic bit_end;
    logic expected_parity;

    uart_rx_bit_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .clk          (clk),
        .reset_n      (reset_n),
        .serial_in    (serial_in),
        .prescale     (p_q),
        .active       (state_q != ST_IDLE),
        .rx_s         (rx_s),
        .sampled_bit  (sampled_bit),
        .sample_strobe(sample_strobe),
        .bit_end      (bit_end)
    );

    assign expected_parity = (^shift_q) ^ (parity_type == PARITY_ODD);

    assign parallel_data = parallel_data_q;
    assign data_valid    = data_valid_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            p_q             <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            par_err_q       <= 1'b0;
            parallel_data_q <= '0;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q         <= ST_START;
                        p_q             <= prescale;
                        bit_cnt_q       <= '0;
                        par_err_q       <= 1'b0;
                        data_valid_q    <= 1'b0;
                        parity_error_q  <= 1'b0;
                        framing_error_q <= 1'b0;
                    end
                end
                ST_START: begin
                    // A start bit that reads high at mid-bit was a glitch.
                    if (sample_strobe && sampled_bit) begin
                        state_q <= ST_IDLE;
                    end else if (bit_end) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample_strobe) begin
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= parity_enable ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_strobe && (sampled_bit != expected_parity)) begin
                        par_err_q <= 1'b1;
                    end
                    if (bit_end) begin
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-stop so a start bit right after the stop bit is caught.
                    if (sample_strobe) begin
                        framing_error_q <= !sampled_bit;
                        parity_error_q  <= par_err_q;
                        if (sampled_bit && !par_err_q) begin
                            parallel_data_q <= shift_q;
                            data_valid_q    <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Only 8, 16 and 32 are legal oversample rates.
    always_ff @(posedge clk) begin
        if (reset_n && (state_q == ST_IDLE) && !rx_s) begin
            assert (prescale_is_legal(int'(prescale)));
        end
    end

endmodule
